// File: rtl/tile_plane_pkg.sv
// Shared types and constants for the tile plane address generator.
package tile_plane_pkg;

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;

  // Slot positions within an 8-pixel tile column
  localparam int unsigned SLOT_LSCR = 0;
  localparam int unsigned SLOT_MAP0 = 1;

  // Per-plane register indices
  localparam int unsigned IDX_XSCR = 0;
  localparam int unsigned IDX_YSCR = 1;
  localparam int unsigned IDX_CTRL = 2;
  localparam int unsigned IDX_RSVD = 3;

  typedef struct packed {
    logic [8:0] sx;
    logic [7:0] sy;
    logic       lsen;
    logic       flipy_en;
  } plane_regs_t;

  typedef enum logic [1:0] {
    FETCH_NONE = 2'd0,
    FETCH_LSCR = 2'd1,
    FETCH_MAP  = 2'd2
  } fetch_t;

endpackage

// File: rtl/tile_plane_seq_if.sv
// Register, VRAM and tile-result buses of the tile plane sequencer.
interface tile_plane_seq_if;
  import tile_plane_pkg::*;

  logic                reg_we;
  logic [3:0]          reg_addr;
  logic [8:0]          reg_din;
  logic [ADDR_W-1:0]   vram_addr;
  logic                vram_rd;
  logic [DATA_W-1:0]   vram_din;
  logic                cpu_slot;
  logic                tile_valid;
  logic [1:0]          tile_plane;
  logic [7:0]          tile_code;
  logic [7:0]          tile_attr;
  logic [2:0]          tile_row;
  logic [2:0]          fine_x;

  modport master (
    input  reg_we, reg_addr, reg_din, vram_din,
    output vram_addr, vram_rd, cpu_slot,
           tile_valid, tile_plane, tile_code, tile_attr, tile_row, fine_x
  );

  modport slave (
    output reg_we, reg_addr, reg_din, vram_din,
    input  vram_addr, vram_rd, cpu_slot,
           tile_valid, tile_plane, tile_code, tile_attr, tile_row, fine_x
  );
endinterface

// File: rtl/tile_plane_raster.sv
// H/V raster counters with hblank, frame-start and vblank interrupt pulses.
module tile_plane_raster
  import tile_plane_pkg::*;
#(
  parameter int unsigned HFIRST    = 32,
  parameter int unsigned HTOTAL    = 384,
  parameter int unsigned HBL_START = 352,
  parameter int unsigned VFIRST    = 248,
  parameter int unsigned VTOTAL    = 264,
  parameter int unsigned VIRQ_LINE = 504
) (
  input  logic             clk_24M,
  input  logic             nRES,
  input  logic             px_ce,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hblank,
  output logic             hvot,
  output logic             vblank_irq,
  output logic [CNT_W-1:0] h_nxt_c,
  output logic [CNT_W-1:0] v_nxt_c,
  output logic             line_start_c
);

  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(HFIRST);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HFIRST + HTOTAL - 1);
  localparam logic [CNT_W-1:0] H_BL    = CNT_W'(HBL_START);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(VFIRST);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VFIRST + VTOTAL - 1);
  localparam logic [CNT_W-1:0] V_IRQ   = CNT_W'(VIRQ_LINE);

  logic h_wrap_c;
  logic v_wrap_c;

  // Next counter values; they equal the current ones while px_ce is low
  always_comb begin
    h_wrap_c     = (hpos == H_LAST);
    v_wrap_c     = h_wrap_c && (vpos == V_LAST);
    h_nxt_c      = hpos;
    v_nxt_c      = vpos;
    line_start_c = px_ce && h_wrap_c;
    if (px_ce) begin
      h_nxt_c = h_wrap_c ? H_FIRST : hpos + CNT_W'(1);
      if (h_wrap_c)
        v_nxt_c = v_wrap_c ? V_FIRST : vpos + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      hpos       <= H_FIRST;
      vpos       <= V_FIRST;
      hblank     <= 1'b0;
      hvot       <= 1'b0;
      vblank_irq <= 1'b0;
    end else begin
      hpos       <= h_nxt_c;
      vpos       <= v_nxt_c;
      hblank     <= (h_nxt_c >= H_BL);
      hvot       <= px_ce && v_wrap_c;
      vblank_irq <= line_start_c && (v_nxt_c == V_IRQ);
    end
  end

endmodule

// File: rtl/tile_plane_seq.sv
// Tile plane address generator: raster, per-plane scroll registers and the
// fixed 8-slot VRAM fetch sequencer feeding a downstream pixel shifter.
module tile_plane_seq
  import tile_plane_pkg::*;
#(
  parameter int unsigned NPLANES   = 2,
  parameter int unsigned HFIRST    = 32,
  parameter int unsigned HTOTAL    = 384,
  parameter int unsigned HBL_START = 352,
  parameter int unsigned VFIRST    = 248,
  parameter int unsigned VTOTAL    = 264,
  parameter int unsigned VIRQ_LINE = 504,
  parameter logic [12:0] MAP_BASE  = 13'h0800,
  parameter logic [12:0] LSCR_BASE = 13'h0000
) (
  input  logic             clk_24M,
  input  logic             nRES,
  input  logic             px_ce,
  input  logic             flip,
  tile_plane_seq_if.master bus,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hblank,
  output logic             hvot,
  output logic             vblank_irq
);

  logic [CNT_W-1:0] h_nxt_c, v_nxt_c;
  logic             line_start_c;

  tile_plane_raster #(
    .HFIRST(HFIRST), .HTOTAL(HTOTAL), .HBL_START(HBL_START),
    .VFIRST(VFIRST), .VTOTAL(VTOTAL), .VIRQ_LINE(VIRQ_LINE)
  ) u_raster (
    .clk_24M(clk_24M), .nRES(nRES), .px_ce(px_ce),
    .hpos(hpos), .vpos(vpos), .hblank(hblank), .hvot(hvot), .vblank_irq(vblank_irq),
    .h_nxt_c(h_nxt_c), .v_nxt_c(v_nxt_c), .line_start_c(line_start_c)
  );

  plane_regs_t pend_q   [NPLANES];
  plane_regs_t act_q    [NPLANES];
  plane_regs_t pend_nxt_c [NPLANES];
  plane_regs_t act_ld_c [NPLANES];
  logic [8:0]  lbuf_q   [NPLANES];

  fetch_t      kind_q, kind_c;
  logic [1:0]  plane_q, plane_c;
  logic [2:0]  row_q, row_c, fx_q, fx_c;
  logic [12:0] addr_c;
  logic [8:0]  hx_c, map_x_c, lp_c;
  logic [7:0]  vy_c, lvy_c, map_y_c;
  logic        hbl_c, flipy_sel_c;

  // Pending registers including this cycle's write; active load at line start
  always_comb begin
    for (int p = 0; p < NPLANES; p++) begin
      pend_nxt_c[p] = pend_q[p];
      if (bus.reg_we && bus.reg_addr[3:2] == 2'(p)) begin
        case (bus.reg_addr[1:0])
          2'(IDX_XSCR): pend_nxt_c[p].sx = bus.reg_din;
          2'(IDX_YSCR): pend_nxt_c[p].sy = bus.reg_din[7:0];
          2'(IDX_CTRL): begin
            pend_nxt_c[p].lsen     = bus.reg_din[0];
            pend_nxt_c[p].flipy_en = bus.reg_din[1];
          end
          2'(IDX_RSVD): ;
        endcase
      end
      act_ld_c[p] = pend_nxt_c[p];
      if (pend_nxt_c[p].lsen)
        act_ld_c[p].sx = lbuf_q[p];
    end
  end

  // Decode the slot about to begin (addresses are registered with the new hpos)
  always_comb begin
    kind_c  = FETCH_NONE;
    plane_c = 2'd0;
    addr_c  = 13'd0;
    row_c   = 3'd0;
    fx_c    = 3'd0;
    map_x_c = 9'd0;
    map_y_c = 8'd0;
    hx_c    = h_nxt_c ^ {9{flip}};
    vy_c    = v_nxt_c[7:0] ^ {8{flip}};
    lvy_c   = vy_c + 8'd1;
    hbl_c   = (h_nxt_c >= 9'(HBL_START));
    lp_c    = (h_nxt_c - 9'(HBL_START)) >> 3;
    for (int p = 0; p < NPLANES; p++) begin
      if (hbl_c && h_nxt_c[2:0] == 3'(SLOT_LSCR) && lp_c == 9'(p) && pend_q[p].lsen) begin
        kind_c  = FETCH_LSCR;
        plane_c = 2'(p);
        addr_c  = LSCR_BASE + 13'({2'(p), lvy_c});
      end
      if (!hbl_c && h_nxt_c[2:0] == 3'(SLOT_MAP0 + p)) begin
        map_x_c = hx_c + act_q[p].sx;
        map_y_c = vy_c + act_q[p].sy;
        kind_c  = FETCH_MAP;
        plane_c = 2'(p);
        addr_c  = MAP_BASE + 13'(p * 2048) + 13'({map_y_c[7:3], map_x_c[8:3]});
        row_c   = map_y_c[2:0];
        fx_c    = act_q[p].sx[2:0];
      end
    end
  end

  always_comb begin
    flipy_sel_c = 1'b0;
    for (int p = 0; p < NPLANES; p++)
      if (plane_q == 2'(p))
        flipy_sel_c = act_q[p].flipy_en;
  end

  // Register file, line buffer and in-flight slot state
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      for (int p = 0; p < NPLANES; p++) begin
        pend_q[p] <= '0;
        act_q[p]  <= '0;
        lbuf_q[p] <= '0;
      end
      kind_q  <= FETCH_NONE;
      plane_q <= 2'd0;
      row_q   <= 3'd0;
      fx_q    <= 3'd0;
    end else begin
      for (int p = 0; p < NPLANES; p++) begin
        pend_q[p] <= pend_nxt_c[p];
        if (line_start_c)
          act_q[p] <= act_ld_c[p];
        if (px_ce && kind_q == FETCH_LSCR && plane_q == 2'(p))
          lbuf_q[p] <= bus.vram_din[8:0];
      end
      if (px_ce) begin
        kind_q  <= kind_c;
        plane_q <= plane_c;
        row_q   <= row_c;
        fx_q    <= fx_c;
      end
    end
  end

  // VRAM bus and tile result outputs
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      bus.vram_addr  <= 13'd0;
      bus.vram_rd    <= 1'b0;
      bus.cpu_slot   <= 1'b0;
      bus.tile_valid <= 1'b0;
      bus.tile_plane <= 2'd0;
      bus.tile_code  <= 8'd0;
      bus.tile_attr  <= 8'd0;
      bus.tile_row   <= 3'd0;
      bus.fine_x     <= 3'd0;
    end else begin
      bus.tile_valid <= 1'b0;
      if (px_ce) begin
        bus.vram_addr <= addr_c;
        bus.vram_rd   <= (kind_c != FETCH_NONE);
        bus.cpu_slot  <= (kind_c == FETCH_NONE);
        if (kind_q == FETCH_MAP) begin
          bus.tile_valid <= 1'b1;
          bus.tile_plane <= plane_q;
          bus.tile_code  <= bus.vram_din[7:0];
          bus.tile_attr  <= bus.vram_din[15:8];
          bus.tile_row   <= row_q ^ {3{bus.vram_din[9] & flipy_sel_c}};
          bus.fine_x     <= fx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_plane_seq.sv
// Directed bench for tile_plane_seq; a 16-line frame keeps full-frame checks short.
module tb_tile_plane_seq;
  import tile_plane_pkg::*;

  logic       clk_24M = 1'b0;
  logic       nRES    = 1'b0;
  logic       px_ce   = 1'b0;
  logic       flip    = 1'b0;
  logic [8:0] hpos, vpos;
  logic       hblank, hvot, vblank_irq;
  logic [7:0] attr_v  = 8'h00;
  int         n_chk   = 0;
  int         n_fail  = 0;
  int         n_px;

  tile_plane_seq_if vif ();

  tile_plane_seq #(.NPLANES(2), .VFIRST(496), .VTOTAL(16)) dut (
    .clk_24M(clk_24M), .nRES(nRES), .px_ce(px_ce), .flip(flip), .bus(vif.master),
    .hpos(hpos), .vpos(vpos), .hblank(hblank), .hvot(hvot), .vblank_irq(vblank_irq)
  );

  always #5 clk_24M = ~clk_24M;

  // VRAM model: line-scroll table returns 0x0123, map words are {attr_v, addr[7:0]}
  assign vif.vram_din = (vif.vram_addr < 13'h0400) ? 16'h0123 : {attr_v, vif.vram_addr[7:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_24M);
    @(negedge clk_24M);
  endtask

  task automatic goto(input logic [8:0] h);
    for (int i = 0; i < 1000 && hpos !== h; i++) tick();
    chk("goto_hpos", 32'(hpos), 32'(h));
  endtask

  task automatic wr(input logic [1:0] pl, input int unsigned idx, input logic [8:0] d);
    vif.reg_we   = 1'b1;
    vif.reg_addr = {pl, 2'(idx)};
    vif.reg_din  = d;
    tick();
    vif.reg_we   = 1'b0;
  endtask

  task automatic chk_tile(input string tag, input logic [1:0] pl, input logic [7:0] code,
                          input logic [2:0] row, input logic [2:0] fx);
    chk({tag, "_valid"}, 32'(vif.tile_valid), 32'h1);
    chk({tag, "_plane"}, 32'(vif.tile_plane), 32'(pl));
    chk({tag, "_code"},  32'(vif.tile_code),  32'(code));
    chk({tag, "_row"},   32'(vif.tile_row),   32'(row));
    chk({tag, "_finex"}, 32'(vif.fine_x),     32'(fx));
  endtask

  initial begin
    vif.reg_we   = 1'b0;
    vif.reg_addr = 4'h0;
    vif.reg_din  = 9'h000;
    px_ce        = 1'b1;
    repeat (2) @(negedge clk_24M);

    // Reset state
    chk("rst_hpos", 32'(hpos), 32'd32);
    chk("rst_vpos", 32'(vpos), 32'd496);
    chk("rst_addr", 32'(vif.vram_addr), 32'h0);
    chk("rst_rd", 32'(vif.vram_rd), 32'h0);
    chk("rst_cpu", 32'(vif.cpu_slot), 32'h0);
    chk("rst_valid", 32'(vif.tile_valid), 32'h0);
    chk("rst_hblank", 32'(hblank), 32'h0);
    chk("rst_hvot", 32'(hvot), 32'h0);

    // First column, no scroll: vy=0xF0, column 4
    nRES = 1'b1;
    tick();
    chk("s1_addr", 32'(vif.vram_addr), 32'h0F84);
    chk("s1_rd", 32'(vif.vram_rd), 32'h1);
    chk("s1_cpu", 32'(vif.cpu_slot), 32'h0);
    tick();
    chk_tile("t0", 2'd0, 8'h84, 3'd0, 3'd0);
    chk("t0_attr", 32'(vif.tile_attr), 32'h00);
    chk("s2_addr", 32'(vif.vram_addr), 32'h1784);
    tick();
    chk_tile("t1", 2'd1, 8'h84, 3'd0, 3'd0);
    chk("s3_rd", 32'(vif.vram_rd), 32'h0);
    chk("s3_cpu", 32'(vif.cpu_slot), 32'h1);
    tick();
    chk("hold_valid", 32'(vif.tile_valid), 32'h0);
    chk("hold_code", 32'(vif.tile_code), 32'h84);

    // px_ce low freezes the raster
    px_ce = 1'b0;
    repeat (3) tick();
    chk("freeze_hpos", 32'(hpos), 32'd36);
    px_ce = 1'b1;

    // X scroll 0x1FF mid-line; writes to plane 2 and reserved index are ignored
    wr(2'd0, IDX_XSCR, 9'h1FF);
    wr(2'd2, IDX_XSCR, 9'h055);
    wr(2'd0, IDX_RSVD, 9'h0AA);
    goto(9'd73);
    chk("xscr_pending_addr", 32'(vif.vram_addr), 32'h0F89);
    goto(9'd351);
    chk("hblank_pre", 32'(hblank), 32'h0);
    tick();
    chk("hblank_at", 32'(hblank), 32'h1);
    chk("no_lscr_rd", 32'(vif.vram_rd), 32'h0);
    goto(9'd33);
    chk("l497_vpos", 32'(vpos), 32'd497);
    chk("xscr_addr", 32'(vif.vram_addr), 32'h0F84);
    tick();
    chk_tile("xscr", 2'd0, 8'h84, 3'd1, 3'd7);

    // Y scroll 0xF8: y = 0xF2 + 0xF8 = 0xEA
    wr(2'd0, IDX_YSCR, 9'h0F8);
    goto(9'd33);
    chk("yscr_addr", 32'(vif.vram_addr), 32'h0F44);
    tick();
    chk_tile("yscr", 2'd0, 8'h44, 3'd2, 3'd7);

    // Line scroll on plane 1, table entry 0x123
    wr(2'd1, IDX_CTRL, 9'h001);
    goto(9'd352);
    chk("lscr_p0_rd", 32'(vif.vram_rd), 32'h0);
    goto(9'd360);
    chk("lscr_rd", 32'(vif.vram_rd), 32'h1);
    chk("lscr_addr", 32'(vif.vram_addr), 32'h01F3);
    goto(9'd34);
    chk("lscr_map_addr", 32'(vif.vram_addr), 32'h17A8);
    tick();
    chk_tile("lscr", 2'd1, 8'hA8, 3'd3, 3'd3);

    // Y flip of tile row: y[2:0]=2 with attr bit1 and FLIPY_EN -> 5
    wr(2'd0, IDX_YSCR, 9'h00E);
    wr(2'd0, IDX_CTRL, 9'h002);
    attr_v = 8'h02;
    goto(9'd33);
    chk("flipy_addr", 32'(vif.vram_addr), 32'h0804);
    tick();
    chk_tile("flipy", 2'd0, 8'h04, 3'd5, 3'd7);
    chk("flipy_attr", 32'(vif.tile_attr), 32'h02);

    // Screen flip: hx and vy inverted
    flip = 1'b1;
    goto(9'd33);
    chk("flip_p0_addr", 32'(vif.vram_addr), 32'h08FB);
    tick();
    chk_tile("flip_p0", 2'd0, 8'hFB, 3'd7, 3'd7);
    chk("flip_p1_addr", 32'(vif.vram_addr), 32'h1060);
    tick();
    chk_tile("flip_p1", 2'd1, 8'h60, 3'd2, 3'd3);
    flip = 1'b0;

    // Write on the line-start cycle takes effect on that line
    goto(9'd415);
    wr(2'd0, IDX_XSCR, 9'h008);
    chk("bypass_hpos", 32'(hpos), 32'd32);
    tick();
    chk("bypass_addr", 32'(vif.vram_addr), 32'h0805);
    tick();
    chk_tile("bypass", 2'd0, 8'h05, 3'd3, 3'd0);

    // vblank_irq on entry to line 504
    for (int i = 0; i < 4000 && !vblank_irq; i++) tick();
    chk("virq_seen", 32'(vblank_irq), 32'h1);
    chk("virq_vpos", 32'(vpos), 32'h1F8);
    chk("virq_hpos", 32'(hpos), 32'd32);
    tick();
    chk("virq_pulse", 32'(vblank_irq), 32'h0);

    // hvot at frame wrap, then once per 16*384 pixels
    for (int i = 0; i < 7000 && !hvot; i++) tick();
    chk("hvot_seen", 32'(hvot), 32'h1);
    chk("hvot_vpos", 32'(vpos), 32'd496);
    chk("hvot_hpos", 32'(hpos), 32'd32);
    n_px = 0;
    do begin
      tick();
      n_px++;
    end while (!hvot && n_px < 7000);
    chk("hvot_period", 32'(n_px), 32'd6144);

    // Reset mid-line
    tick();
    tick();
    chk("pre_rst_valid", 32'(vif.tile_valid), 32'h1);
    chk("pre_rst_code", 32'(vif.tile_code), 32'hC5);
    nRES = 1'b0;
    #1;
    chk("mrst_hpos", 32'(hpos), 32'd32);
    chk("mrst_vpos", 32'(vpos), 32'd496);
    chk("mrst_valid", 32'(vif.tile_valid), 32'h0);
    chk("mrst_code", 32'(vif.tile_code), 32'h0);
    chk("mrst_rd", 32'(vif.vram_rd), 32'h0);
    chk("mrst_addr", 32'(vif.vram_addr), 32'h0);
    tick();
    nRES = 1'b1;
    tick();
    chk("post_rst_valid", 32'(vif.tile_valid), 32'h0);
    chk("post_rst_addr", 32'(vif.vram_addr), 32'h0F84);
    tick();
    chk_tile("post_rst", 2'd0, 8'h84, 3'd0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_plane_seq.md
Name: tile_plane_seq

Overview:
- Parametrised successor to the k052109 plane address generator.
- Owns the H/V raster counters and a fixed 8-slot VRAM fetch sequencer per tile column.
- Serves 1..4 scrolled tile planes with per-plane X/Y scroll, optional per-line X scroll table, screen flip, and a CPU access slot.
- Emits serialized tile fetch results (code, attribute, row-in-tile, fine X) for a downstream k051962-class pixel shifter.

Parameters:
- NPLANES, 2, number of tile planes (1..4).
- HFIRST, 32, first H count value; counter wraps to it.
- HTOTAL, 384, H counts per line.
- HBL_START, 352, H count where hblank and line-scroll fetch begin.
- VFIRST, 248, first V count value.
- VTOTAL, 264, lines per frame.
- VIRQ_LINE, 504, V count raising vblank_irq.
- MAP_BASE, 13'h0800, VRAM word base of plane 0 map; plane p is at MAP_BASE + p*2048.
- LSCR_BASE, 13'h0000, VRAM word base of the line-scroll table.

Ports:
- clk_24M  in  1  system clock
- nRES  in  1  async active-low reset
- px_ce  in  1  pixel enable, one clk_24M pulse per pixel
- reg_we  in  1  register write strobe
- reg_addr  in  4  {plane[1:0], idx[1:0]}
- reg_din  in  9  register write data
- flip  in  1  screen flip
- vram_addr  out  13  VRAM word address
- vram_rd  out  1  renderer owns VRAM this slot
- vram_din  in  16  VRAM data: [7:0] code, [15:8] attribute
- cpu_slot  out  1  slot free for CPU access
- tile_valid  out  1  one-cycle strobe: tile fields valid
- tile_plane  out  2  plane of current result
- tile_code  out  8  tile code
- tile_attr  out  8  tile attribute
- tile_row  out  3  row within tile
- fine_x  out  3  fine X scroll for the plane
- hpos  out  9  H counter
- vpos  out  9  V counter
- hblank  out  1  h >= HBL_START
- hvot  out  1  one-cycle pulse at frame start
- vblank_irq  out  1  one-cycle pulse at line VIRQ_LINE

Behaviour:
- Reset: all outputs 0. hpos=HFIRST, vpos=VFIRST. All scroll registers 0. Line-scroll disabled. Sequencer at slot 0.

Counters (advance only on px_ce):
- hpos runs HFIRST..HFIRST+HTOTAL-1, then wraps to HFIRST.
- vpos increments on H wrap. It runs VFIRST..VFIRST+VTOTAL-1, 9-bit.
- hvot pulses on the px_ce where both counters wrap.
- vblank_irq pulses on the px_ce where vpos becomes VIRQ_LINE.

Effective coordinates:
- hx = hpos ^ {9{flip}}; vy = vpos[7:0] ^ {8{flip}}.

Slot sequencer:
- slot = hpos[2:0].
- Slot 0 with hblank high: line-scroll fetch for plane p = (hpos-HBL_START)>>3, if p<NPLANES and LSEN[p]. vram_addr = LSCR_BASE + {p, vy+1 (8b, wraps)}.
- Slot 1+p, p<NPLANES, hblank low: map fetch for plane p.
  - sx = active X scroll (9b), sy = Y scroll (8b).
  - x = hx+sx mod 512; y = vy+sy mod 256.
  - vram_addr = MAP_BASE + p*2048 + {y[7:3], x[8:3]}.
- All other slots: vram_rd=0, cpu_slot=1, vram_addr=0.
- vram_rd=1 for the whole of any fetch slot.
- vram_din is sampled on the px_ce that ends a map slot. On that cycle:
  - tile_valid=1, tile_plane=p, tile_code/attr from vram_din.
  - tile_row = y[2:0] ^ {3{attr[1] & FLIPY_EN[p]}}.
  - fine_x = sx[2:0].
- Outputs hold until the next tile_valid.

Registers, per plane:
- idx0: X scroll, 9b.
- idx1: Y scroll, 8b.
- idx2: bit0 LSEN, bit1 FLIPY_EN.
- idx3: reserved, ignored.
- reg_addr plane >= NPLANES is ignored.
- Writes go to pending copies. Pending is copied to active on the px_ce where hpos wraps (line start).
- A write in that same cycle is included via write-through bypass.

Line scroll:
- A fetched word's [8:0] is held in a line buffer.
- At line start, if LSEN[p], active X scroll = line buffer, overriding the register.
- If LSEN is cleared mid-line, the register value applies from the next line start.

Other rules:
- Fetch timing is fixed; there is no handshake with VRAM.
- px_ce low freezes all state.
- Reset mid-line returns to the reset state immediately. No tile_valid is issued until the first slot 1 after release.

Decomposition:
- Package tile_plane_pkg: slot encoding constants, register index constants, plane_regs_t struct {sx[8:0], sy[7:0], lsen, flipy_en}.
- Sub-module tile_plane_raster: H/V counters, hblank, hvot, vblank_irq.
- The top level holds the sequencer, registers and address mux.

Test Plan:
- Release nRES, run one line with scroll 0, flip 0, NPLANES=2 → at hpos=0x020 slot 1, vram_addr=0x0800+{vy[7:3],6'h04}; tile_valid follows one px_ce later with vram_din fields.
- Write X scroll=0x1FF mid-line → unchanged until line start; then x=hx-1 (wraps at 0x000 to 0x1FF); fine_x=7.
- Y scroll=0x0F8 at vpos=0x0F8 → y=0xF0, map row field 5'h1E, tile_row=0.
- Set LSEN for plane 1, table entry for the next line = 0x123 → next line map column = (hx+0x123)[8:3], fine_x=3.
- Attr bit1=1 with FLIPY_EN set, y[2:0]=2 → tile_row=5; with flip=1 the addresses follow the inverted hx/vy.
- Run a full frame → hvot once per 384*264 px_ce; vblank_irq at vpos=0x1F8; assert nRES low mid-frame → all outputs 0 immediately.
